// File: rtl/bram_req_arbiter.sv
// Zero-fills a single-port bit-masked BRAM after reset, then shares it between two req/gnt ports.
// Define BRAM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module bram_req_arbiter #(
  parameter  int RAM_WIDTH = 32,
  parameter  int RAM_DEPTH = 1024,
  localparam int AW        = $clog2(RAM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0,
  input  logic [AW-1:0]        i_addr0,
  input  logic                 i_we0,
  input  logic [RAM_WIDTH-1:0] i_wstrb0,
  input  logic [RAM_WIDTH-1:0] i_wdata0,
  input  logic                 i_req1,
  input  logic [AW-1:0]        i_addr1,
  input  logic                 i_we1,
  input  logic [RAM_WIDTH-1:0] i_wstrb1,
  input  logic [RAM_WIDTH-1:0] i_wdata1,
  output logic                 o_gnt0,
  output logic                 o_gnt1,
  output logic                 o_rvalid0,
  output logic                 o_rvalid1,
  output logic [RAM_WIDTH-1:0] o_rdata0,
  output logic [RAM_WIDTH-1:0] o_rdata1,
  output logic                 o_init_done,
  output logic                 o_ram_cs,
  output logic [AW-1:0]        o_ram_addr,
  output logic                 o_ram_we,
  output logic [RAM_WIDTH-1:0] o_ram_wstrb,
  output logic [RAM_WIDTH-1:0] o_ram_din,
  input  logic [RAM_WIDTH-1:0] i_ram_dout,
  input  logic                 i_ram_ready
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  state_t        r_state;
  logic [AW-1:0] r_init_cnt;
  logic          r_init_done;
  logic          r_pend;
  logic          r_owner;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_p0_wins;

`ifdef BRAM_ARB_RR_EN
  logic          r_last;
  // Port 0 wins contention whenever port 1 was the last one granted.
  assign w_p0_wins = r_last;
`else
  assign w_p0_wins = 1'b1;
`endif

  // Grant selection: only in RUN and only while the RAM can take an access.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!i_rst && (r_state == ST_RUN) && i_ram_ready) begin
      if (i_req0 && (!i_req1 || w_p0_wins)) begin
        w_gnt0 = 1'b1;
      end else if (i_req1) begin
        w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = 1'b0;
      end
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // RAM port mux: zero-fill pattern in INIT, granted requester in RUN, idle zeros otherwise.
  always_comb begin
    o_ram_cs    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wstrb = '0;
    o_ram_din   = '0;
    if (i_rst) begin
      o_ram_cs = 1'b0;
    end else if (r_state == ST_INIT) begin
      o_ram_cs    = i_ram_ready;
      o_ram_we    = i_ram_ready;
      o_ram_addr  = r_init_cnt;
      o_ram_wstrb = '1;
      o_ram_din   = '0;
    end else if (w_gnt0) begin
      o_ram_cs    = 1'b1;
      o_ram_we    = i_we0;
      o_ram_addr  = i_addr0;
      o_ram_wstrb = i_wstrb0;
      o_ram_din   = i_wdata0;
    end else if (w_gnt1) begin
      o_ram_cs    = 1'b1;
      o_ram_we    = i_we1;
      o_ram_addr  = i_addr1;
      o_ram_wstrb = i_wstrb1;
      o_ram_din   = i_wdata1;
    end else begin
      o_ram_cs = 1'b0;
    end
  end

  // Init/run FSM with zero-fill counter, read-return tracking and arbitration pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_pend      <= 1'b0;
      r_owner     <= 1'b0;
`ifdef BRAM_ARB_RR_EN
      r_last      <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_INIT: begin
          r_pend <= 1'b0;
          if (i_ram_ready) begin
            if (r_init_cnt == LAST_ADDR) begin
              r_state     <= ST_RUN;
              r_init_cnt  <= '0;
              r_init_done <= 1'b1;
            end else begin
              r_init_cnt <= r_init_cnt + AW'(1);
            end
          end
        end
        ST_RUN: begin
          r_pend <= (w_gnt0 & ~i_we0) | (w_gnt1 & ~i_we1);
          if (w_gnt0 | w_gnt1) begin
            r_owner <= w_gnt1;
`ifdef BRAM_ARB_RR_EN
            r_last  <= w_gnt1;
`endif
          end
        end
        default: begin
          r_state     <= ST_INIT;
          r_init_cnt  <= '0;
          r_init_done <= 1'b0;
          r_pend      <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt0      = w_gnt0;
  assign o_gnt1      = w_gnt1;
  assign o_rvalid0   = r_pend & ~r_owner;
  assign o_rvalid1   = r_pend & r_owner;
  assign o_rdata0    = i_ram_dout;
  assign o_rdata1    = i_ram_dout;
  assign o_init_done = r_init_done;

endmodule
